// File: rtl/serial_add_ctrl.sv
// -----------------------------------------------------------------------------
// serial_add_ctrl
//
// Bit-serial adder/subtractor. A single 1-bit full-adder cell processes
// the operands LSB first, one bit per clock, so an operation of WIDTH bits
// takes WIDTH RUN cycles plus one DONE cycle.
//
// Subtraction is done as A + ~B + 1: the B register is loaded inverted and
// the carry register is preset to 1, so the same cell serves both modes and
// COUT=1 after a subtract means "no borrow".
//
// Ports
//   CLK    in   clock, all state changes on the rising edge
//   RST    in   synchronous active-high reset, overrides everything
//   START  in   request an operation (only looked at in IDLE)
//   SUB    in   0: A+B+CIN, 1: A-B (captured with START)
//   A, B   in   WIDTH-bit operands (captured with START)
//   CIN    in   carry-in for add, ignored for subtract
//   BUSY   out  high in RUN and DONE
//   DONE   out  one-cycle pulse, S/COUT/OVF valid
//   S      out  result; shows partial shifts during RUN
//   COUT   out  carry out of the MSB
//   OVF    out  signed overflow
// -----------------------------------------------------------------------------
module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic             SUB,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             CIN,
  output logic             BUSY,
  output logic             DONE,
  output logic [WIDTH-1:0] S,
  output logic             COUT,
  output logic             OVF
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t           state_reg;
  logic [WIDTH-1:0] a_sh_reg;
  logic [WIDTH-1:0] b_sh_reg;
  logic [WIDTH-1:0] s_sh_reg;
  logic             carry_reg;
  logic [CW-1:0]    cnt_reg;
  logic             busy_reg;
  logic             done_reg;
  logic             cout_reg;
  logic             ovf_reg;

  // The one and only full-adder cell, fed from the operand LSBs.
  logic fa_a;
  logic fa_b;
  logic fa_sum;
  logic fa_carry;
  logic last_bit;

  assign fa_a     = a_sh_reg[0];
  assign fa_b     = b_sh_reg[0];
  assign fa_sum   = fa_a ^ fa_b ^ carry_reg;
  assign fa_carry = (fa_a & fa_b) | (carry_reg & (fa_a ^ fa_b));
  assign last_bit = (cnt_reg == CW'(WIDTH - 1));

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_reg <= ST_IDLE;
      a_sh_reg  <= '0;
      b_sh_reg  <= '0;
      s_sh_reg  <= '0;
      carry_reg <= 1'b0;
      cnt_reg   <= '0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
      cout_reg  <= 1'b0;
      ovf_reg   <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          done_reg <= 1'b0;
          if (START) begin
            a_sh_reg  <= A;
            b_sh_reg  <= SUB ? ~B : B;
            carry_reg <= SUB ? 1'b1 : CIN;
            cnt_reg   <= '0;
            busy_reg  <= 1'b1;
            state_reg <= ST_RUN;
          end
        end

        ST_RUN: begin
          s_sh_reg  <= {fa_sum, s_sh_reg[WIDTH-1:1]};
          a_sh_reg  <= {1'b0, a_sh_reg[WIDTH-1:1]};
          b_sh_reg  <= {1'b0, b_sh_reg[WIDTH-1:1]};
          carry_reg <= fa_carry;
          cnt_reg   <= cnt_reg + 1'b1;
          if (last_bit) begin
            // carry_reg is the carry into the MSB at this point, fa_carry
            // the carry out of it; their difference flags signed overflow.
            cout_reg  <= fa_carry;
            ovf_reg   <= carry_reg ^ fa_carry;
            done_reg  <= 1'b1;
            state_reg <= ST_DONE;
          end
        end

        ST_DONE: begin
          done_reg  <= 1'b0;
          busy_reg  <= 1'b0;
          state_reg <= ST_IDLE;
        end

        default: begin
          done_reg  <= 1'b0;
          busy_reg  <= 1'b0;
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

  assign BUSY = busy_reg;
  assign DONE = done_reg;
  assign S    = s_sh_reg;
  assign COUT = cout_reg;
  assign OVF  = ovf_reg;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// -----------------------------------------------------------------------------
// tb_serial_add_ctrl
//
// Two instances: WIDTH=8 for directed and random operations, WIDTH=2 for the
// exhaustive back-to-back sweep with START held high. Expected results come
// from plain integer arithmetic on the operands.
// -----------------------------------------------------------------------------
module tb_serial_add_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic       start8, sub8, cin8;
  logic [7:0] a8, b8;
  logic       busy8, done8, cout8, ovf8;
  logic [7:0] s8;

  logic       start2, sub2, cin2;
  logic [1:0] a2, b2;
  logic       busy2, done2, cout2, ovf2;
  logic [1:0] s2;

  int checks = 0;
  int errors = 0;

  serial_add_ctrl #(.WIDTH(8)) dut8 (
    .CLK(clk), .RST(rst), .START(start8), .SUB(sub8), .A(a8), .B(b8),
    .CIN(cin8), .BUSY(busy8), .DONE(done8), .S(s8), .COUT(cout8), .OVF(ovf8)
  );

  serial_add_ctrl #(.WIDTH(2)) dut2 (
    .CLK(clk), .RST(rst), .START(start2), .SUB(sub2), .A(a2), .B(b2),
    .CIN(cin2), .BUSY(busy2), .DONE(done2), .S(s2), .COUT(cout2), .OVF(ovf2)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: w-bit add/subtract computed with wide integers.
  function automatic void ref_op(input int w, input longint a, input longint b,
                                 input bit cin, input bit sub,
                                 output longint s, output bit cout, output bit ovf);
    longint m, half, sa, sb, full, sfull;
    m    = longint'(1) << w;
    half = m / 2;
    sa   = (a >= half) ? a - m : a;
    sb   = (b >= half) ? b - m : b;
    if (!sub) begin
      full  = a + b + longint'(cin);
      sfull = sa + sb + longint'(cin);
      cout  = (full >= m);
    end else begin
      full  = a - b;
      sfull = sa - sb;
      cout  = (a >= b);
    end
    s   = full & (m - 1);
    ovf = (sfull >= half) || (sfull < -half);
  endfunction

  // One WIDTH=8 operation. Called at a falling edge with the DUT in IDLE;
  // returns at the falling edge one cycle after DONE.
  task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic cin,
                      input logic sub, input bit disturb, input string tag);
    longint es;
    bit     ec, eo;
    int     done_cyc, busy_cnt, late_busy;
    done_cyc = 0;
    busy_cnt = 0;
    late_busy = 0;
    ref_op(8, longint'(a), longint'(b), cin, sub, es, ec, eo);
    a8 = a; b8 = b; cin8 = cin; sub8 = sub; start8 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start8 = 1'b0;
    for (int cyc = 1; cyc <= 20; cyc++) begin
      if (busy8) busy_cnt++;
      if (done8) begin
        done_cyc = cyc;
        break;
      end
      // Operands wander during RUN; they must not affect the result.
      a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom); sub8 = 1'($urandom);
      if (disturb && cyc == 3) begin
        start8 = 1'b1;
        a8     = 8'hAA;
      end else begin
        start8 = 1'b0;
      end
      @(negedge clk);
    end
    start8 = 1'b0;
    $display("op %s A=%02h B=%02h CIN=%0d SUB=%0d -> S=%02h COUT=%0d OVF=%0d done_cyc=%0d exp S=%02h COUT=%0d OVF=%0d",
             tag, a, b, cin, sub, s8, cout8, ovf8, done_cyc, es[7:0], ec, eo);
    check({tag, " latency"}, 32'(done_cyc), 32'd9);
    check({tag, " busy_cycles"}, 32'(busy_cnt), 32'd9);
    check({tag, " S"}, {24'd0, s8}, 32'(es));
    check({tag, " COUT"}, {31'd0, cout8}, {31'd0, ec});
    check({tag, " OVF"}, {31'd0, ovf8}, {31'd0, eo});
    @(negedge clk);
    check({tag, " done_pulse"}, {31'd0, done8}, 32'd0);
    check({tag, " busy_after"}, {31'd0, busy8}, 32'd0);
    if (disturb) begin
      for (int k = 0; k < 12; k++) begin
        @(negedge clk);
        if (busy8 || done8) late_busy++;
      end
      check({tag, " no_second_op"}, 32'(late_busy), 32'd0);
    end
  endtask

  initial begin
    longint es;
    bit     ec, eo;
    int     ndone, last_cyc;
    logic [5:0] k6;

    rst = 1'b1;
    start8 = 1'b0; sub8 = 1'b0; cin8 = 1'b0; a8 = '0; b8 = '0;
    start2 = 1'b0; sub2 = 1'b0; cin2 = 1'b0; a2 = '0; b2 = '0;
    repeat (2) @(negedge clk);
    check("reset S", {24'd0, s8}, 32'd0);
    check("reset COUT", {31'd0, cout8}, 32'd0);
    check("reset OVF", {31'd0, ovf8}, 32'd0);
    check("reset DONE", {31'd0, done8}, 32'd0);
    check("reset BUSY", {31'd0, busy8}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    run8(8'h0F, 8'h01, 1'b0, 1'b0, 1'b0, "add_0F_01");
    run8(8'hFF, 8'h01, 1'b0, 1'b0, 1'b0, "add_FF_01");
    run8(8'h7F, 8'h00, 1'b1, 1'b0, 1'b0, "add_7F_00_c");

    // Idle with START low: results must hold.
    repeat (3) begin
      a8 = 8'($urandom); b8 = 8'($urandom);
      @(negedge clk);
    end
    check("hold S", {24'd0, s8}, 32'h80);
    check("hold COUT", {31'd0, cout8}, 32'd0);
    check("hold OVF", {31'd0, ovf8}, 32'd1);
    check("hold BUSY", {31'd0, busy8}, 32'd0);

    run8(8'h05, 8'h07, 1'b1, 1'b1, 1'b0, "sub_05_07");
    run8(8'h80, 8'h01, 1'b0, 1'b1, 1'b0, "sub_80_01");

    // Reset in RUN cycle 4 of an operation.
    a8 = 8'hFF; b8 = 8'hFF; cin8 = 1'b1; sub8 = 1'b0; start8 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start8 = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst S", {24'd0, s8}, 32'd0);
    check("midrst COUT", {31'd0, cout8}, 32'd0);
    check("midrst OVF", {31'd0, ovf8}, 32'd0);
    check("midrst DONE", {31'd0, done8}, 32'd0);
    check("midrst BUSY", {31'd0, busy8}, 32'd0);
    $display("op midrst reset applied during RUN cycle 4");
    run8(8'h10, 8'h20, 1'b0, 1'b0, 1'b0, "after_rst_10_20");

    run8(8'h01, 8'h01, 1'b0, 1'b0, 1'b1, "busy_reject");

    for (int i = 0; i < 40; i++) begin
      run8(8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom), 1'b0, "random");
    end

    // WIDTH=2 exhaustive sweep, START held high throughout.
    ndone = 0;
    last_cyc = 0;
    k6 = 6'd0;
    a2 = k6[1:0]; b2 = k6[3:2]; cin2 = k6[4]; sub2 = k6[5];
    start2 = 1'b1;
    for (int cyc = 1; cyc <= 300; cyc++) begin
      @(negedge clk);
      if (done2) begin
        k6 = 6'(ndone);
        ref_op(2, longint'(k6[1:0]), longint'(k6[3:2]), k6[4], k6[5], es, ec, eo);
        $display("w2 #%0d A=%0d B=%0d CIN=%0d SUB=%0d -> S=%0d COUT=%0d OVF=%0d cyc=%0d exp S=%0d COUT=%0d OVF=%0d",
                 ndone, k6[1:0], k6[3:2], k6[4], k6[5], s2, cout2, ovf2, cyc, es, ec, eo);
        check("w2 S", {30'd0, s2}, 32'(es));
        check("w2 COUT", {31'd0, cout2}, {31'd0, ec});
        check("w2 OVF", {31'd0, ovf2}, {31'd0, eo});
        if (ndone == 0) check("w2 first_latency", 32'(cyc), 32'd3);
        else            check("w2 spacing", 32'(cyc - last_cyc), 32'd4);
        last_cyc = cyc;
        ndone++;
        if (ndone == 64) break;
        k6 = 6'(ndone);
        a2 = k6[1:0]; b2 = k6[3:2]; cin2 = k6[4]; sub2 = k6[5];
      end
    end
    start2 = 1'b0;
    check("w2 done_count", 32'(ndone), 32'd64);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
